// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock through a single
// full adder cell, with the carry held in a flip-flop between bits.

module structuralFullAdder (
   output logic sum,
   output logic carryout,
   input  logic a,
   input  logic b,
   input  logic carryin
);

   logic w_axb;
   logic w_gen;
   logic w_prop;

   assign w_axb    = a ^ b;
   assign sum      = w_axb ^ carryin;
   assign w_gen    = a & b;
   assign w_prop   = w_axb & carryin;
   assign carryout = w_gen | w_prop;

endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_c;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             w_faSum;
   logic             w_faCout;
   logic             w_load;
   logic             w_last;

   structuralFullAdder u_fa (
      .sum      (w_faSum),
      .carryout (w_faCout),
      .a        (r_a[0]),
      .b        (r_b[0]),
      .carryin  (r_c)
   );

   // A new operation may begin from IDLE or straight out of DONE.
   assign w_load = ((r_state == IDLE) || (r_state == DONE)) && start;
   assign w_last = (r_state == RUN) && (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = start ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operands shift right so bit i reaches the adder on the i-th RUN cycle;
   // the result fills from the MSB so bit i settles at position i.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a    <= '0;
         r_b    <= '0;
         r_c    <= 1'b0;
         r_res  <= '0;
         r_cnt  <= '0;
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else if (w_load) begin
         r_a   <= a;
         r_b   <= b;
         r_c   <= carryin;
         r_res <= '0;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_a   <= {1'b0, r_a[WIDTH-1:1]};
         r_b   <= {1'b0, r_b[WIDTH-1:1]};
         r_c   <= w_faCout;
         r_res <= {w_faSum, r_res[WIDTH-1:1]};
         if (!w_last) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_last) begin
            r_sum  <= {w_faSum, r_res[WIDTH-1:1]};
            r_cout <= w_faCout;
         end
      end
   end

   assign busy     = (r_state == RUN);
   assign done     = (r_state == DONE);
   assign sum      = r_sum;
   assign carryout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8: a vector table
// plus hand-written sequences for reset, input isolation and back-to-back use.

module tb_serial_adder;

   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH-1:0] expSum;
      logic             expCout;
   } vector_t;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carryin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carryout;

   int               testsRun;
   int               testsFailed;
   logic [WIDTH:0]   prevResult;
   vector_t          vectors[8];

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .carryin  (carryin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carryout (carryout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Called just after a falling edge with the DUT in IDLE or DONE; returns
   // just after the falling edge that follows the completion edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                input logic vcin, input logic [WIDTH-1:0] expSum,
                                input logic expCout, input string tag);
      start   = 1'b1;
      a       = va;
      b       = vb;
      carryin = vcin;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         a       = WIDTH'($urandom);
         b       = WIDTH'($urandom);
         carryin = 1'($urandom);
         checkOutput({tag, "_run_busyDone"}, {30'd0, busy, done}, 32'b10);
         checkOutput({tag, "_run_hold"}, {23'd0, carryout, sum}, {23'd0, prevResult});
         @(negedge clk);
      end
      checkOutput({tag, "_done_busyDone"}, {30'd0, busy, done}, 32'b01);
      checkOutput({tag, "_result"}, {23'd0, carryout, sum}, {23'd0, expCout, expSum});
      prevResult = {expCout, expSum};
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      prevResult  = '0;

      vectors[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
      vectors[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vectors[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vectors[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vectors[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
      vectors[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vectors[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vectors[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

      // Reset held two cycles with start high must not launch anything.
      reset   = 1'b1;
      start   = 1'b1;
      a       = 8'hFF;
      b       = 8'hFF;
      carryin = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("reset_busyDone", {30'd0, busy, done}, 32'b00);
         checkOutput("reset_result", {23'd0, carryout, sum}, 32'd0);
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checkOutput("postReset_busyDone", {30'd0, busy, done}, 32'b00);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vectors[i].a, vectors[i].b, vectors[i].cin,
                       vectors[i].expSum, vectors[i].expCout, $sformatf("vec%0d", i));
         @(negedge clk);
         checkOutput($sformatf("vec%0d_pulseEnd", i), {30'd0, busy, done}, 32'b00);
      end

      // start and operand changes during RUN are ignored.
      start   = 1'b1;
      a       = 8'h0F;
      b       = 8'h01;
      carryin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         start = (k == 2);
         if (k == 2) a = 8'hAA;
         checkOutput("iso_run_busyDone", {30'd0, busy, done}, 32'b10);
         checkOutput("iso_run_hold", {23'd0, carryout, sum}, {23'd0, prevResult});
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("iso_done_busyDone", {30'd0, busy, done}, 32'b01);
      checkOutput("iso_result", {23'd0, carryout, sum}, {23'd0, 1'b0, 8'h11});
      prevResult = {1'b0, 8'h11};
      @(negedge clk);
      checkOutput("iso_noSecondOp", {30'd0, busy, done}, 32'b00);

      // Back-to-back: the second start is taken on the edge leaving DONE.
      applyStimulus(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "b2bFirst");
      applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "b2bSecond");
      start = 1'b0;
      @(negedge clk);
      checkOutput("b2b_pulseEnd", {30'd0, busy, done}, 32'b00);

      // Reset on the third RUN edge aborts the operation and clears outputs.
      start   = 1'b1;
      a       = 8'h12;
      b       = 8'h34;
      carryin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midReset_busyDone", {30'd0, busy, done}, 32'b00);
      checkOutput("midReset_result", {23'd0, carryout, sum}, 32'd0);
      prevResult = '0;
      reset = 1'b0;
      applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "afterReset");
      @(negedge clk);
      checkOutput("afterReset_pulseEnd", {30'd0, busy, done}, 32'b00);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
